// File: rtl/adder_seq_ctrl.sv
// Sequencing controller for a two-register adder datapath: IDLE -> EXEC -> WB per instruction.
// Optional SKPZ conditional-skip support is enabled by defining ADDER_SEQ_SKIP_EN.
module adder_seq_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [DATA_W-1:0] instr_imm,
    output logic              ctl_nla,
    output logic              ctl_nlb,
    output logic              ctl_ea,
    output logic              ctl_eb,
    output logic              ctl_eu,
    output logic              ctl_sub,
    output logic [DATA_W-1:0] bus_drv,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              cf_in,
    input  logic              zf_in,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              skipped,
    output logic [1:0]        dbg_state_o
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE, and op/imm are ignored at all other times.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_OUTA = 3'b101;
    localparam logic [2:0] OP_OUTB = 3'b110;
    localparam logic [2:0] OP_SKPZ = 3'b111;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                skip_cur_q, skip_cur_d;
    logic                skip_pend_q, skip_pend_d;
    logic                flag_c_q, flag_c_d;
    logic                flag_z_q, flag_z_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                exec_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            imm_q       <= '0;
            skip_cur_q  <= 1'b0;
            skip_pend_q <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            skip_cur_q  <= skip_cur_d;
            skip_pend_q <= skip_pend_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        skip_cur_d  = skip_cur_q;
        skip_pend_d = skip_pend_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        out_d       = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d        = instr_op;
                    imm_d       = instr_imm;
                    // A pending skip is consumed by whichever instruction is accepted next.
                    skip_cur_d  = skip_pend_q;
                    skip_pend_d = 1'b0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                if (!skip_cur_q) begin
                    unique case (op_q)
                        OP_ADD, OP_SUB: begin
                            flag_c_d = cf_in;
                            flag_z_d = zf_in;
                        end
                        OP_OUTA, OP_OUTB: out_d = bus_in;
                        OP_SKPZ: begin
`ifdef ADDER_SEQ_SKIP_EN
                            if (flag_z_q) skip_pend_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them without waiting for an edge.
    assign exec_live   = (state_q == S_EXEC) && !skip_cur_q;
    assign instr_ready = (state_q == S_IDLE);
    assign bus_oe      = exec_live && ((op_q == OP_LDA) || (op_q == OP_LDB));
    assign bus_drv     = bus_oe ? imm_q : '0;
    assign ctl_nla     = !(exec_live && ((op_q == OP_LDA) || (op_q == OP_ADD) || (op_q == OP_SUB)));
    assign ctl_nlb     = !(exec_live && (op_q == OP_LDB));
    assign ctl_ea      = exec_live && (op_q == OP_OUTA);
    assign ctl_eb      = exec_live && (op_q == OP_OUTB);
    assign ctl_eu      = exec_live && ((op_q == OP_ADD) || (op_q == OP_SUB));
    assign ctl_sub     = exec_live && (op_q == OP_SUB);
    assign done        = (state_q == S_WB);
    assign out_data    = out_q;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign dbg_state_o = state_q;

`ifdef ADDER_SEQ_SKIP_EN
    assign skipped = (state_q == S_WB) && skip_cur_q;
`else
    assign skipped = 1'b0;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a small A/B/ALU datapath around the DUT, an instruction-level model,
// a per-cycle compare process and directed instruction sequences with literal expectations.
module tb_adder_seq_ctrl;

    localparam int W = 8;
`ifdef ADDER_SEQ_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'd0, LDA = 3'd1, LDB = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, OUTA = 3'd5, OUTB = 3'd6, SKPZ = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic [2:0]   instr_op = 3'd0;
    logic [W-1:0] instr_imm = '0;
    logic         instr_ready, ctl_nla, ctl_nlb, ctl_ea, ctl_eb, ctl_eu, ctl_sub, bus_oe;
    logic [W-1:0] bus_drv, bus_in, out_data;
    logic         cf_in, zf_in, done, flag_c, flag_z, skipped;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    adder_seq_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm), .ctl_nla(ctl_nla), .ctl_nlb(ctl_nlb),
        .ctl_ea(ctl_ea), .ctl_eb(ctl_eb), .ctl_eu(ctl_eu), .ctl_sub(ctl_sub),
        .bus_drv(bus_drv), .bus_oe(bus_oe), .bus_in(bus_in), .cf_in(cf_in), .zf_in(zf_in),
        .done(done), .out_data(out_data), .flag_c(flag_c), .flag_z(flag_z),
        .skipped(skipped), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- datapath environment ----------------
    logic [W-1:0] reg_a = '0;
    logic [W-1:0] reg_b = '0;
    logic [W:0]   alu_full;
    logic [W-1:0] alu_res;

    always_comb begin
        alu_full = ctl_sub ? ({1'b0, reg_a} - {1'b0, reg_b}) : ({1'b0, reg_a} + {1'b0, reg_b});
        alu_res  = alu_full[W-1:0];
        cf_in    = alu_full[W];          // carry on add, borrow on subtract
        zf_in    = (alu_res == '0);
        bus_in   = bus_oe ? bus_drv : ctl_ea ? reg_a : ctl_eb ? reg_b : ctl_eu ? alu_res : '0;
    end

    always @(posedge clk) begin
        if (!ctl_nla) reg_a <= bus_in;
        if (!ctl_nlb) reg_b <= bus_in;
    end

    // ---------------- instruction-level model ----------------
    int           m_phase = 0;   // 0 idle, 1 execute cycle, 2 writeback cycle
    logic [2:0]   m_op = 3'd0;
    logic [W-1:0] m_imm = '0, m_a = '0, m_b = '0, m_out = '0;
    bit           m_c = 0, m_z = 0, m_pend = 0, m_skip = 0;
    int           m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_c = 0; m_z = 0; m_out = '0; m_pend = 0; m_skip = 0;
        end else if (m_phase == 0) begin
            if (instr_valid) begin
                m_op = instr_op; m_imm = instr_imm; m_skip = m_pend; m_pend = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!m_skip) begin
                case (m_op)
                    LDA:  m_a = m_imm;
                    LDB:  m_b = m_imm;
                    ADD:  begin
                        m_sum = int'(m_a) + int'(m_b);
                        m_c = (m_sum > 255); m_a = W'(m_sum % 256); m_z = (m_a == 0);
                    end
                    SUB:  begin
                        m_c = (m_a < m_b); m_a = W'((int'(m_a) - int'(m_b) + 256) % 256); m_z = (m_a == 0);
                    end
                    OUTA: m_out = m_a;
                    OUTB: m_out = m_b;
                    SKPZ: if (SKIP_EN && m_z) m_pend = 1;
                    default: ;
                endcase
            end
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [27:0] act_v, exp_v;
    bit          ex;
    int          done_cnt = 0, skip_cnt = 0;
    logic        last_sub = 1'b0;

    always @(negedge clk) begin
        ex = (m_phase == 1) && !m_skip;
        exp_v = {m_phase == 0,
                 ex && (m_op == LDA || m_op == LDB),
                 (ex && (m_op == LDA || m_op == LDB)) ? m_imm : 8'h00,
                 !(ex && (m_op == LDA || m_op == ADD || m_op == SUB)),
                 !(ex && m_op == LDB),
                 ex && m_op == OUTA, ex && m_op == OUTB,
                 ex && (m_op == ADD || m_op == SUB), ex && m_op == SUB,
                 m_phase == 2, m_phase == 2 && m_skip,
                 m_c, m_z, m_out};
        act_v = {instr_ready, bus_oe, bus_drv, ctl_nla, ctl_nlb, ctl_ea, ctl_eb, ctl_eu,
                 ctl_sub, done, skipped, flag_c, flag_z, out_data};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, act_v, exp_v);
        end
        checks++;
        if ($countones({bus_oe, ctl_ea, ctl_eb, ctl_eu}) > 1) begin
            errors++;
            $display("FAIL bus_onehot t=%0t got=%b exp=at most one", $time, {bus_oe, ctl_ea, ctl_eb, ctl_eu});
        end
        if (done) done_cnt++;
        if (skipped) skip_cnt++;
        if (ctl_eu) last_sub = ctl_sub;
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] imm, input bit junk);
        int guard = 0;
        while (!instr_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 20) chk("ready_timeout", 32'd0, 32'd1);
        instr_valid = 1'b1; instr_op = op; instr_imm = imm;
        @(posedge clk); #1;
        if (junk) begin
            instr_op = 3'($urandom_range(0, 7)); instr_imm = W'($urandom_range(0, 255));
        end else begin
            instr_valid = 1'b0;
        end
        @(posedge clk); #1;
        if (junk) begin
            instr_op = 3'($urandom_range(0, 7)); instr_imm = W'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int d0;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_nla", ctl_nla, 1);
        chk("reset_done", done, 0);
        chk("reset_out", out_data, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", instr_ready, 1);

        // LDA 0x05 timing
        @(posedge clk); #1;
        instr_valid = 1'b1; instr_op = LDA; instr_imm = 8'h05;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("lda_exec_oe", bus_oe, 1);
        chk("lda_exec_drv", bus_drv, 8'h05);
        chk("lda_exec_nla", ctl_nla, 0);
        chk("lda_exec_ready", instr_ready, 0);
        @(negedge clk);
        chk("lda_wb_done", done, 1);
        @(negedge clk);
        chk("lda_idle_ready", instr_ready, 1);
        chk("lda_idle_done", done, 0);
        @(posedge clk); #1;

        // 0xFF + 0x01 wraps with carry and zero
        issue(LDA, 8'hFF, 0);
        issue(LDB, 8'h01, 0);
        issue(ADD, 8'h00, 0);
        chk("add_flag_c", flag_c, 1);
        chk("add_flag_z", flag_z, 1);
        chk("add_sub_sel", last_sub, 0);

        // 3 - 3 = 0, no borrow
        issue(LDA, 8'h03, 0);
        issue(LDB, 8'h03, 0);
        issue(SUB, 8'h00, 0);
        chk("sub_sub_sel", last_sub, 1);
        issue(OUTA, 8'h00, 0);
        chk("sub_out", out_data, 8'h00);
        chk("sub_flag_z", flag_z, 1);
        chk("sub_flag_c", flag_c, 0);
        issue(NOP, 8'h00, 0);
        issue(OUTB, 8'h00, 0);
        chk("outb_out", out_data, 8'h03);

        // valid held high with changing op after acceptance
        issue(LDA, 8'h11, 1);
        issue(LDB, 8'h2C, 1);
        issue(ADD, 8'h00, 1);
        issue(OUTA, 8'h00, 0);
        chk("junk_out", out_data, 8'h3D);
        chk("junk_flag_c", flag_c, 0);

        // reset during ADD execute
        rst_n = 1'b0; #3 rst_n = 1'b1;
        issue(LDA, 8'h40, 0);
        issue(LDB, 8'h02, 0);
        d0 = done_cnt;
        instr_valid = 1'b1; instr_op = ADD; instr_imm = 8'h00;
        @(posedge clk); #2;
        chk("abort_pre_eu", ctl_eu, 1);
        rst_n = 1'b0; #1;
        chk("abort_nla", ctl_nla, 1);
        chk("abort_eu", ctl_eu, 0);
        chk("abort_done", done, 0);
        instr_valid = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_flag_c", flag_c, 0);
        chk("abort_flag_z", flag_z, 0);
        issue(OUTA, 8'h00, 0);
        chk("abort_a_kept", out_data, 8'h40);

        // conditional skip
        d0 = skip_cnt;
        issue(LDA, 8'h05, 0);
        issue(LDB, 8'h05, 0);
        issue(SUB, 8'h00, 0);
        issue(LDA, 8'h22, 0);
        issue(SKPZ, 8'h00, 0);
        chk("skpz_flag_z", flag_z, 1);
        issue(LDA, 8'h7E, 0);
        issue(OUTA, 8'h00, 0);
        chk("skip_outa", out_data, SKIP_EN ? 8'h22 : 8'h7E);
        issue(SKPZ, 8'h00, 0);
        issue(SKPZ, 8'h00, 0);
        issue(LDA, 8'h33, 0);
        issue(OUTA, 8'h00, 0);
        chk("skip_no_chain", out_data, 8'h33);
        chk("skip_pulses", skip_cnt - d0, SKIP_EN ? 2 : 0);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
